// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants and the SRAM slave state encoding.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } slave_state_e;

endpackage

// File: rtl/ahb_byte_lane_dec.sv
// Maps transfer size and low address bits to a little-endian byte-lane strobe,
// and flags addresses that are not aligned to the transfer size.
module ahb_byte_lane_dec #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]                      size_i,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] addr_lo_i,
  output logic [DATA_WIDTH/8-1:0]         strb_o,
  output logic                            misalign_o
);

  localparam int NB = DATA_WIDTH / 8;

  // A lane is selected when it shares every address bit above the size boundary.
  always_comb begin
    strb_o = '0;
    for (int b = 0; b < NB; b++) begin
      strb_o[b] = ((b ^ int'(addr_lo_i)) >> size_i) == 0;
    end
    misalign_o = (int'(addr_lo_i) & ((1 << size_i) - 1)) != 0;
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: register-array memory with byte-lane writes,
// configurable wait states and two-cycle ERROR responses.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0]            MAX_SIZE  = (DATA_WIDTH == 64) ? HSIZE_DWORD : HSIZE_WORD;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [3:0]            WAIT_INIT = 4'(WAIT_STATES);

  slave_state_e          state_q, state_d, accept_tgt;
  logic [3:0]            cnt_q, cnt_d;
  logic [IW-1:0]         idx_q;
  logic [NB-1:0]         strb_q;
  logic                  write_q;
  logic                  accept, xfer_err, misalign;
  logic [NB-1:0]         strb;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic                  unused_ok;

  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  ahb_byte_lane_dec #(.DATA_WIDTH(DATA_WIDTH)) u_lane_dec (
    .size_i     (HSIZE),
    .addr_lo_i  (HADDR[LB-1:0]),
    .strb_o     (strb),
    .misalign_o (misalign)
  );

  // HREADY high means any earlier data phase is ending, so accept in every state.
  assign accept   = HSEL && HREADY && HTRANS[1];
  assign xfer_err = ((HADDR >> LB) >= DEPTH_A) || (HSIZE > MAX_SIZE) || misalign;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept_tgt = S_DATA;
    if (xfer_err) begin
      accept_tgt = S_ERR1;
    end else if (WAIT_STATES > 0) begin
      accept_tgt = S_WAIT;
    end
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_DATA;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = accept ? accept_tgt : S_IDLE;
    endcase
    if (state_d == S_WAIT && state_q != S_WAIT) begin
      cnt_d = WAIT_INIT;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      strb_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= HADDR[LB +: IW];
        strb_q  <= strb;
        write_q <= HWRITE;
      end
    end
  end

  // Contents are deliberately not reset; only OKAY writes ever reach S_DATA.
  always_ff @(posedge HCLK) begin
    if (state_q == S_DATA && write_q) begin
      for (int b = 0; b < NB; b++) begin
        if (strb_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  assign HREADYOUT = !(state_q == S_WAIT || state_q == S_ERR1);
  assign HRESP     = (state_q == S_ERR1 || state_q == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = (state_q == S_DATA && !write_q) ? mem_q[idx_q] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: a zero-wait and a two-wait instance driven by a
// pipelined master, checked every cycle against a transaction-level model.
module tb_ahb_sram_slave;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic        HCLK;
  logic        HRESETn;
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [1:0]  htrans    [2];
  logic [31:0] hwdata    [2];
  logic        hreadyout [2];
  logic        hresp     [2];
  logic [31:0] hrdata    [2];

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] nxt_wd      [2];
  int          ph_low      [2];
  int          low_total   [2];
  logic        ph_resp_low [2];
  logic        ph_resp     [2];
  logic [31:0] ph_rdata    [2];
  logic [33:0] cmp_e, cmp_g;
  time         t0, t1;

  // Transaction-level model: one outstanding transfer per slave, counted down to completion.
  bit          m_busy [2];
  bit          m_err  [2];
  bit          m_wr   [2];
  int          m_left [2];
  int          m_idx  [2];
  int          m_lo   [2];
  int          m_nb   [2];
  logic [31:0] mmem   [2][256];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ahb_sram_slave #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MEM_DEPTH  (256),
      .WAIT_STATES(g == 0 ? 0 : 2)
    ) u_dut (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .HSEL     (hsel[g]),
      .HADDR    (haddr[g]),
      .HWRITE   (hwrite[g]),
      .HSIZE    (hsize[g]),
      .HBURST   (3'b001),
      .HPROT    (4'b0011),
      .HTRANS   (htrans[g]),
      .HMASTLOCK(1'b0),
      .HREADY   (hreadyout[g]),
      .HWDATA   (hwdata[g]),
      .HREADYOUT(hreadyout[g]),
      .HRESP    (hresp[g]),
      .HRDATA   (hrdata[g])
    );
  end

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  function automatic bit m_ready(input int k);
    return !m_busy[k] || m_left[k] == 0;
  endfunction

  function automatic bit m_is_err(input logic [31:0] a, input logic [2:0] sz);
    return (a >= 32'h400) || (sz > 3'd2) || ((a & ((32'd1 << sz) - 32'd1)) != 32'd0);
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int k = 0; k < 2; k++) m_busy[k] <= 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_busy[k]) begin
          if (m_left[k] > 0) begin
            m_left[k] <= m_left[k] - 1;
          end else begin
            if (!m_err[k] && m_wr[k]) begin
              for (int b = 0; b < 4; b++) begin
                if (b >= m_lo[k] && b < m_lo[k] + m_nb[k])
                  mmem[k][m_idx[k]][8*b +: 8] <= hwdata[k][8*b +: 8];
              end
            end
            m_busy[k] <= 1'b0;
          end
        end
        if (hsel[k] && htrans[k][1] && m_ready(k)) begin
          m_busy[k] <= 1'b1;
          m_err[k]  <= m_is_err(haddr[k], hsize[k]);
          m_left[k] <= m_is_err(haddr[k], hsize[k]) ? 1 : ((k == 0) ? 0 : 2);
          m_wr[k]   <= hwrite[k];
          m_idx[k]  <= int'(haddr[k][9:2]);
          m_lo[k]   <= int'(haddr[k][1:0]);
          m_nb[k]   <= 1 << hsize[k];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Presents one address phase, holding it (and the previous beat's write data) until accepted.
  task automatic beat(input int k, input logic [1:0] tr, input logic [31:0] a, input logic w,
                      input logic [2:0] sz, input logic [31:0] wd, input logic sel);
    logic r;
    bit   done;
    hsel[k]   = sel;
    htrans[k] = tr;
    haddr[k]  = a;
    hwrite[k] = w;
    hsize[k]  = sz;
    hwdata[k] = nxt_wd[k];
    ph_low[k] = 0;
    done      = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge HCLK);
      r = hreadyout[k];
      if (r) begin
        ph_resp[k]  = hresp[k];
        ph_rdata[k] = hrdata[k];
      end else begin
        ph_low[k]++;
        ph_resp_low[k] = hresp[k];
      end
      @(posedge HCLK);
      #1;
      done = r;
    end
    low_total[k] += ph_low[k];
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_timeout dut%0d: HREADYOUT stayed 0 for 40 cycles, required 1", k);
    end
    nxt_wd[k] = wd;
  endtask

  task automatic wr(input int k, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    beat(k, T_NSEQ, a, 1'b1, sz, d, 1'b1);
  endtask

  task automatic rd(input int k, input logic [31:0] a);
    beat(k, T_NSEQ, a, 1'b0, 3'd2, 32'($urandom), 1'b1);
  endtask

  task automatic idle(input int k);
    beat(k, T_IDLE, 32'($urandom), 1'b0, 3'd0, 32'($urandom), 1'b0);
  endtask

  initial begin
    logic [1:0]  tr;
    logic [2:0]  sz;
    logic [31:0] a;
    int          m;
    HRESETn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      hsel[k] = 1'b0; haddr[k] = '0; hwrite[k] = 1'b0; hsize[k] = '0;
      htrans[k] = T_IDLE; hwdata[k] = '0; nxt_wd[k] = '0; low_total[k] = 0;
    end

    fork
      forever begin
        @(negedge HCLK);
        for (int k = 0; k < 2; k++) begin
          cmp_e = {m_ready(k), m_busy[k] && m_err[k],
                   (m_busy[k] && m_left[k] == 0 && !m_err[k] && !m_wr[k]) ? mmem[k][m_idx[k]] : 32'h0};
          cmp_g = {hreadyout[k], hresp[k], hrdata[k]};
          n_cmp++;
          if (cmp_g !== cmp_e) begin
            n_bad++;
            $display("FAIL cycle dut%0d t=%0t: HREADYOUT/HRESP/HRDATA got %b/%b/%h expected %b/%b/%h",
                     k, $time, cmp_g[33], cmp_g[32], cmp_g[31:0], cmp_e[33], cmp_e[32], cmp_e[31:0]);
          end
        end
      end
    join_none

    #12;
    for (int k = 0; k < 2; k++) begin
      chk("reset_hreadyout", 32'(hreadyout[k]), 32'd1);
      chk("reset_hresp", 32'(hresp[k]), 32'd0);
      chk("reset_hrdata", hrdata[k], 32'd0);
    end
    #10 HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // Give every word a known value.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++)
        beat(k, (i == 0) ? T_NSEQ : T_SEQ, 32'(i * 4), 1'b1, 3'd2, 32'($urandom), 1'b1);
      idle(k);
    end

    m = low_total[0];
    wr(0, 32'h10, 3'd2, 32'hDEADBEEF); rd(0, 32'h10); idle(0);
    chk("word_readback", ph_rdata[0], 32'hDEADBEEF);
    chk("word_resp", 32'(ph_resp[0]), 32'd0);
    wr(0, 32'h20, 3'd2, 32'h11223344); wr(0, 32'h22, 3'd0, 32'h00AA0000); rd(0, 32'h20); idle(0);
    chk("byte_lane", ph_rdata[0], 32'h11AA3344);
    wr(0, 32'h20, 3'd1, 32'h0000BBCC); rd(0, 32'h20); idle(0);
    chk("half_lane", ph_rdata[0], 32'h11AABBCC);
    chk("zero_wait_no_stall", 32'(low_total[0] - m), 32'd0);

    wr(0, 32'h0, 3'd2, 32'h01020304); wr(0, 32'h400, 3'd2, 32'hFFFFFFFF); idle(0);
    chk("err_range_low_cycles", 32'(ph_low[0]), 32'd1);
    chk("err_range_resp_first", 32'(ph_resp_low[0]), 32'd1);
    chk("err_range_resp_second", 32'(ph_resp[0]), 32'd1);
    wr(0, 32'h2, 3'd2, 32'hEEEEEEEE); idle(0);
    chk("err_misalign_low_cycles", 32'(ph_low[0]), 32'd1);
    chk("err_misalign_resp", 32'(ph_resp_low[0] & ph_resp[0]), 32'd1);
    rd(0, 32'h0); idle(0);
    chk("err_mem_unchanged", ph_rdata[0], 32'h01020304);

    t0 = $time;
    m  = low_total[0];
    beat(0, T_NSEQ, 32'h40, 1'b1, 3'd2, 32'hA0A0A0A0, 1'b1);
    beat(0, T_SEQ,  32'h44, 1'b1, 3'd2, 32'hA1A1A1A1, 1'b1);
    beat(0, T_BUSY, 32'h48, 1'b1, 3'd2, 32'h5A5A5A5A, 1'b1);
    beat(0, T_SEQ,  32'h48, 1'b1, 3'd2, 32'hA2A2A2A2, 1'b1);
    beat(0, T_SEQ,  32'h4C, 1'b1, 3'd2, 32'hA3A3A3A3, 1'b1);
    rd(0, 32'h4C);
    idle(0);
    t1 = $time;
    chk("incr4_overlap_read", ph_rdata[0], 32'hA3A3A3A3);
    chk("incr4_cycles", 32'((t1 - t0) / 10), 32'd7);
    chk("incr4_no_stall", 32'(low_total[0] - m), 32'd0);

    wr(1, 32'h10, 3'd2, 32'h55AA55AA); rd(1, 32'h10); idle(1);
    chk("ws2_low_cycles", 32'(ph_low[1]), 32'd2);
    chk("ws2_rdata", ph_rdata[1], 32'h55AA55AA);

    wr(1, 32'h30, 3'd2, 32'hCAFEF00D); idle(1);
    hsel[1] = 1'b1; htrans[1] = T_NSEQ; haddr[1] = 32'h30; hwrite[1] = 1'b1; hsize[1] = 3'd2;
    @(posedge HCLK);
    #1;
    hsel[1] = 1'b0; htrans[1] = T_IDLE; hwdata[1] = 32'h12345678;
    chk("wait_before_reset", 32'(hreadyout[1]), 32'd0);
    #2 HRESETn = 1'b0;
    #1;
    chk("async_reset_hreadyout", 32'(hreadyout[1]), 32'd1);
    chk("async_reset_hresp", 32'(hresp[1]), 32'd0);
    chk("async_reset_hrdata", hrdata[1], 32'd0);
    repeat (2) @(posedge HCLK);
    #3 HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    rd(1, 32'h30); idle(1);
    chk("reset_dropped_write", ph_rdata[1], 32'hCAFEF00D);

    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 400; n++) begin
        case ($urandom_range(0, 9))
          0:       tr = T_IDLE;
          1:       tr = T_BUSY;
          2, 3, 4: tr = T_NSEQ;
          default: tr = T_SEQ;
        endcase
        sz = 3'($urandom_range(0, 3));
        m  = int'($urandom_range(0, 19));
        if (m == 0)
          a = 32'(($urandom_range(1, 255) << 10) | ($urandom_range(0, 255) << 2));
        else if (m == 1)
          a = 32'($urandom_range(0, 1023));
        else if (sz < 3'd3)
          a = 32'(($urandom_range(0, 255) << 2) | (($urandom_range(0, 3) >> sz) << sz));
        else
          a = 32'($urandom_range(0, 255) << 2);
        beat(k, tr, a, 1'($urandom_range(0, 1)), sz, 32'($urandom), 1'($urandom_range(0, 9) != 0));
      end
      idle(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
